// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
// Optional feature macro: ADDSUB_SATURATE_EN (saturating result on overflow).
package addsub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Saturation bound for a w-bit signed value: max positive, or most negative when neg=1.
    // Callers truncate the 64-bit result to w bits.
    function automatic logic [63:0] sat_value(input int w, input logic neg);
        if (neg)
            return ~64'd0 << (w - 1);
        else
            return (64'd1 << (w - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// Operand/result handshake bundle for addsub_serial.
// master drives operands and out_ready; slave is the arithmetic engine.
interface addsub_serial_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         c0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] R;
    logic         ovf;
    logic         cout;
    logic         z;

    modport master (
        output in_valid, A, B, c0, out_ready,
        input  in_ready, out_valid, R, ovf, cout, z
    );

    modport slave (
        input  in_valid, A, B, c0, out_ready,
        output in_ready, out_valid, R, ovf, cout, z
    );
endinterface

// File: rtl/addsub_digit.sv
// D-bit combinational ripple-carry adder used once per digit cycle.
module addsub_digit #(
    parameter int D = 4
) (
    input  logic [D-1:0] a,
    input  logic [D-1:0] b,
    input  logic         cin,
    output logic [D-1:0] s,
    output logic         cout
);
    logic [D:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < D; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[D];
endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor: W bits, D bits per cycle, N=W/D RUN cycles.
// Build with ADDSUB_SATURATE_EN defined to clamp R on signed overflow.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int W = 16,
    parameter int D = 4
) (
    input logic            clk,
    input logic            rst,
    addsub_serial_if.slave bus
);
    localparam int N  = W / D;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t         state;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   r_sh;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic           a_msb;
    logic           b_msb;
    logic           ovf_q;
    logic           cout_q;
    logic           z_q;

    logic [D-1:0]   dsum;
    logic           dcarry;
    logic [W-1:0]   r_next;
    logic [W-1:0]   r_final;
    logic           ovf_next;

    addsub_digit #(.D(D)) u_digit (
        .a    (a_sh[D-1:0]),
        .b    (b_sh[D-1:0]),
        .cin  (carry),
        .s    (dsum),
        .cout (dcarry)
    );

    // New digit enters at the MSB end; after N digits the LSB digit has reached bit 0.
    if (D == W) begin : g_one_digit
        assign r_next = dsum;
    end else begin : g_multi_digit
        assign r_next = {dsum, r_sh[W-1:D]};
    end

    // Operand MSBs are kept separately because the shift registers lose them.
    assign ovf_next = (a_msb == b_msb) && (r_next[W-1] != a_msb);

`ifdef ADDSUB_SATURATE_EN
    localparam logic [W-1:0] SAT_MAX = W'(sat_value(W, 1'b0));
    localparam logic [W-1:0] SAT_MIN = W'(sat_value(W, 1'b1));
    assign r_final = ovf_next ? (a_msb ? SAT_MIN : SAT_MAX) : r_next;
`else
    assign r_final = r_next;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf_q  <= 1'b0;
            cout_q <= 1'b0;
            z_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= bus.A;
                        b_sh  <= bus.B ^ {W{bus.c0}};
                        a_msb <= bus.A[W-1];
                        b_msb <= bus.B[W-1] ^ bus.c0;
                        carry <= bus.c0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> D;
                    b_sh  <= b_sh >> D;
                    carry <= dcarry;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        r_sh   <= r_final;
                        ovf_q  <= ovf_next;
                        cout_q <= dcarry;
                        z_q    <= (r_final == '0);
                        state  <= DONE;
                    end else begin
                        r_sh <= r_next;
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.R         = r_sh;
    assign bus.ovf       = ovf_q;
    assign bus.cout      = cout_q;
    assign bus.z         = z_q;
endmodule
